// File: rtl/mux_sched_pkg.sv
// Shared types and widths for the round-robin mux scheduler.
package mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SWITCH = 2'd2
    } sched_state_t;

    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational rotating priority encoder: first set request at or above ptr, wrapping.
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N_REQ = 8,
    parameter int W     = SEL_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     ptr,
    output logic [W-1:0]     winner,
    output logic             any
);

    logic [W-1:0] idx_s;

    // Scan from the farthest offset down so the nearest request to ptr is written last.
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        idx_s  = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_s = ptr + W'(i);
            if (req[idx_s]) begin
                winner = idx_s;
                any    = 1'b1;
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner scheduler for the registered 8:1 mux: grant, bounded burst, one dead cycle.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N_REQ     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_in,
    input  logic                       enable_in,
    output logic [N_REQ-1:0]           gnt_out,
    output logic [$clog2(N_REQ)-1:0]   sel_out,
    output logic                       sel_valid_out,
    output logic                       data_valid_out
);

    localparam int SW = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    sched_state_t     state_r,     state_nxt_s;
    logic [N_REQ-1:0] gnt_r,       gnt_nxt_s;
    logic [SW-1:0]    sel_r,       sel_nxt_s;
    logic [SW-1:0]    ptr_r,       ptr_nxt_s;
    logic [CNT_W-1:0] burst_cnt_r, cnt_nxt_s;
    logic             sel_valid_r, sel_valid_nxt_s;
    logic             data_valid_r;
    logic [SW-1:0]    winner_s;
    logic             any_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .W     (SW)
    ) u_pick (
        .req    (req_in),
        .ptr    (ptr_r),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state logic; requests are only sampled outside GRANT.
    always_comb begin
        state_nxt_s     = state_r;
        gnt_nxt_s       = '0;
        sel_nxt_s       = sel_r;
        sel_valid_nxt_s = 1'b0;
        ptr_nxt_s       = ptr_r;
        cnt_nxt_s       = burst_cnt_r;
        case (state_r)
            IDLE, SWITCH: begin
                if (enable_in && any_s) begin
                    state_nxt_s     = GRANT;
                    gnt_nxt_s       = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                    sel_nxt_s       = winner_s;
                    sel_valid_nxt_s = 1'b1;
                    cnt_nxt_s       = '0;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end
            end
            GRANT: begin
                // Enable is deliberately ignored here so an issued burst always completes.
                if (!req_in[sel_r] || (burst_cnt_r == LAST_CNT)) begin
                    state_nxt_s = SWITCH;
                    ptr_nxt_s   = sel_r + SW'(1'b1);
                    cnt_nxt_s   = '0;
                end else begin
                    gnt_nxt_s       = gnt_r;
                    sel_valid_nxt_s = 1'b1;
                    cnt_nxt_s       = burst_cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            gnt_r        <= '0;
            sel_r        <= '0;
            ptr_r        <= '0;
            burst_cnt_r  <= '0;
            sel_valid_r  <= 1'b0;
            data_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            gnt_r        <= gnt_nxt_s;
            sel_r        <= sel_nxt_s;
            ptr_r        <= ptr_nxt_s;
            burst_cnt_r  <= cnt_nxt_s;
            sel_valid_r  <= sel_valid_nxt_s;
            data_valid_r <= sel_valid_r;
        end
    end

    assign gnt_out        = gnt_r;
    assign sel_out        = sel_r;
    assign sel_valid_out  = sel_valid_r;
    assign data_valid_out = data_valid_r;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed-vector bench for mux_rr_scheduler with hand-computed grant sequences.
module tb_mux_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic       enable_in;
    logic [7:0] gnt_out;
    logic [2:0] sel_out;
    logic       sel_valid_out;
    logic       data_valid_out;

    int vec_cnt;
    int err_cnt;

    mux_rr_scheduler #(
        .N_REQ     (8),
        .MAX_BURST (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_in         (req_in),
        .enable_in      (enable_in),
        .gnt_out        (gnt_out),
        .sel_out        (sel_out),
        .sel_valid_out  (sel_valid_out),
        .data_valid_out (data_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        check_vec({tag, "_gnt"}, 32'(gnt_out), 32'h0);
        check_vec({tag, "_sel"}, 32'(sel_out), 32'h0);
        check_vec({tag, "_sv"},  32'(sel_valid_out), 32'h0);
        check_vec({tag, "_dv"},  32'(data_valid_out), 32'h0);
    endtask

    task automatic do_reset(input logic [7:0] req_after);
        rst_n = 1'b0;
        #1;
        check_idle_outs("rst");
        cyc();
        req_in    = req_after;
        enable_in = 1'b1;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_gnt [6];
        logic       exp_dv  [6];
        vec_cnt   = 0;
        err_cnt   = 0;
        req_in    = 8'h00;
        enable_in = 1'b1;
        rst_n     = 1'b0;
        #2;
        check_idle_outs("por");

        // Single continuous request on requester 2
        do_reset(8'h04);
        exp_gnt = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04};
        exp_dv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            cyc();
            check_vec("single_gnt", 32'(gnt_out), 32'(exp_gnt[i]));
            check_vec("single_sel", 32'(sel_out), 32'd2);
            check_vec("single_sv",  32'(sel_valid_out), 32'(exp_gnt[i] != 8'h00));
            check_vec("single_dv",  32'(data_valid_out), 32'(exp_dv[i]));
        end

        // All requesting: 0..7 then 0, four cycles each, one dead cycle between
        do_reset(8'hFF);
        for (int o = 0; o < 9; o++) begin
            for (int b = 0; b < 4; b++) begin
                cyc();
                check_vec("all_gnt", 32'(gnt_out), 32'(8'h01 << (o % 8)));
                check_vec("all_sel", 32'(sel_out), 32'(o % 8));
            end
            cyc();
            check_vec("all_dead_gnt", 32'(gnt_out), 32'h0);
            check_vec("all_dead_sel", 32'(sel_out), 32'(o % 8));
        end

        // Early release: owner 5 drops after two grant cycles, 1 waiting
        do_reset(8'h20);
        cyc();
        check_vec("early_g1", 32'(gnt_out), 32'h20);
        req_in = 8'h22;
        cyc();
        check_vec("early_g2", 32'(gnt_out), 32'h20);
        req_in = 8'h02;
        cyc();
        check_vec("early_sw", 32'(gnt_out), 32'h00);
        check_vec("early_sw_sel", 32'(sel_out), 32'd5);
        cyc();
        check_vec("early_next", 32'(gnt_out), 32'h02);
        check_vec("early_next_sel", 32'(sel_out), 32'd1);

        // Wrap-around: after owner 7, 0 wins, then 7 again
        do_reset(8'h80);
        cyc();
        check_vec("wrap_g7", 32'(gnt_out), 32'h80);
        req_in = 8'h81;
        for (int i = 0; i < 4; i++) cyc();
        check_vec("wrap_sw1", 32'(gnt_out), 32'h00);
        cyc();
        check_vec("wrap_g0", 32'(gnt_out), 32'h01);
        check_vec("wrap_g0_sel", 32'(sel_out), 32'd0);
        for (int i = 0; i < 4; i++) cyc();
        check_vec("wrap_sw2", 32'(gnt_out), 32'h00);
        cyc();
        check_vec("wrap_g7b", 32'(gnt_out), 32'h80);
        check_vec("wrap_g7b_sel", 32'(sel_out), 32'd7);

        // Enable gating mid-burst of owner 3
        do_reset(8'h08);
        cyc();
        cyc();
        enable_in = 1'b0;
        req_in    = 8'h28;
        cyc();
        check_vec("en_g3", 32'(gnt_out), 32'h08);
        cyc();
        check_vec("en_g4", 32'(gnt_out), 32'h08);
        cyc();
        check_vec("en_sw", 32'(gnt_out), 32'h00);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_vec("en_off_gnt", 32'(gnt_out), 32'h00);
            check_vec("en_off_sv",  32'(sel_valid_out), 32'h0);
        end
        enable_in = 1'b1;
        cyc();
        check_vec("en_resume_gnt", 32'(gnt_out), 32'h20);
        check_vec("en_resume_sel", 32'(sel_out), 32'd5);

        // Reset mid-burst of owner 6
        do_reset(8'h40);
        cyc();
        cyc();
        check_vec("mid_g6", 32'(gnt_out), 32'h40);
        check_vec("mid_dv", 32'(data_valid_out), 32'h1);
        do_reset(8'h41);
        cyc();
        check_vec("mid_after_gnt", 32'(gnt_out), 32'h01);
        check_vec("mid_after_sel", 32'(sel_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler that shares the registered 8:1 bit mux between eight requesters. It grants one requester at a time and drives the mux select. It holds each grant for a bounded burst and flags the cycles in which the mux output carries the granted requester's data. It sits directly in front of the mux: `sel_out` feeds the mux select, and `data_valid_out` qualifies the mux output.

## Interface
- `N_REQ`, default 8: number of requesters; power of two, 2..8; mux select width is `$clog2(N_REQ)`.
- `MAX_BURST`, default 4: maximum consecutive grant cycles per owner; range 1..15.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_in`  in  N_REQ: per-requester request level; held high while the requester wants the mux.
- `enable_in`  in  1: scheduler enable; when low, no new grant is issued.
- `gnt_out`  out  N_REQ: one-hot grant; all zero when no owner.
- `sel_out`  out  $clog2(N_REQ): mux select; index of the current or last owner.
- `sel_valid_out`  out  1: high while `gnt_out` is non-zero.
- `data_valid_out`  out  1: `sel_valid_out` delayed one cycle; aligns with the registered mux output.

## Operation
- **FSM states:** IDLE, GRANT, SWITCH.
- **IDLE**
  - `gnt_out`=0 and `sel_valid_out`=0.
  - If `enable_in` is high and `req_in` is non-zero: pick the winner, go to GRANT.
  - The winner's one-hot grant and index are registered on the same edge.
- **Winner pick:** the first set `req_in` bit searching upward from `ptr`, wrapping modulo `N_REQ`.
- **GRANT**
  - `gnt_out`=one-hot(owner), `sel_out`=owner, `sel_valid_out`=1.
  - `burst_cnt` increments each GRANT cycle; it starts at 0 on entry.
- **Leaving GRANT:** go to SWITCH when `req_in[owner]` is low or `burst_cnt`==`MAX_BURST`-1.
  - On that edge `ptr` becomes (owner+1) mod `N_REQ`.
  - Result: the last owner has lowest priority next time.
- **SWITCH** (one dead cycle)
  - `gnt_out`=0 and `sel_valid_out`=0; `sel_out` holds the last owner.
  - If `enable_in` is high and any request is pending: go to GRANT with a new winner picked from `ptr`; otherwise go to IDLE.
  - The old owner may win again only if it is the sole requester.
- **`enable_in` low during GRANT:** the current burst completes normally; no further grant is issued.
- **Owner drops `req_in` on the first GRANT cycle:** a burst of 1 cycle, then SWITCH.
- **Reset** (asserted any time, including mid-burst), all values immediate:
  - State=IDLE.
  - `gnt_out`=0, `sel_out`=0, `sel_valid_out`=0, `data_valid_out`=0.
  - `ptr`=0, `burst_cnt`=0.
- **Widths:** `burst_cnt` is 4 bits; `ptr` and `sel_out` are `$clog2(N_REQ)` bits and wrap naturally.

## Timing
- **Grant latency:** a request sampled high at edge t (IDLE, enabled) gives `gnt_out` high after edge t.
- **Burst length:** a continuous request gets exactly `MAX_BURST` grant cycles, then exactly one SWITCH cycle.
- **Mux data alignment:** `data_valid_out` rises one cycle after `sel_valid_out`, matching the one-cycle register latency of the mux.
- **Request sampling:** requests are sampled only in IDLE and SWITCH; new requests arriving during GRANT wait for the next SWITCH.

## Structure
- **Package `mux_sched_pkg`:**
  - State enum `sched_state_t` {IDLE, GRANT, SWITCH}.
  - Localparams `SEL_W` and `CNT_W`=4.
- **Sub-module `rr_pick`:** purely combinational rotating priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: `winner` index, `any`.
  - Instantiated once in the top.
- **Top level:** contains the FSM, the `burst_cnt`, `ptr` and output registers, and the `data_valid` delay flop.

## Test plan
- **Single continuous request:** `req_in`=8'b0000_0100 from reset release.
  - `gnt_out`=0x04 and `sel_out`=2 for 4 cycles, then 1 SWITCH cycle with `gnt_out`=0, repeating.
  - `data_valid_out` lags `sel_valid_out` by 1 cycle.
- **All requesting:** `req_in`=0xFF.
  - Grant order 0,1,2,…,7,0, each for 4 cycles, separated by single dead cycles.
- **Early release:** owner 5 drops `req_in` after 2 grant cycles while 1 is also requesting.
  - 2-cycle burst for 5, SWITCH, then `gnt_out`=0x02.
- **Wrap-around priority:** last owner 7; `req_in`=0x81.
  - Next grant is 0, then 7.
- **Enable gating:** `enable_in` cleared mid-burst of owner 3.
  - Burst completes, FSM goes to IDLE, no grant while `req_in`≠0.
  - Re-enabling grants from `ptr`=4.
- **Reset mid-burst:** `rst_n` low during GRANT of owner 6.
  - All outputs 0 immediately.
  - After release with `req_in`=0x41, first grant goes to 0.
